// File: rtl/mtr_drv_if.sv
// Bundle between the balance controller and the motor drive back end:
// speed words and current comparators in, gate drives and status out.
interface mtr_drv_if #(
    parameter int DATA_W = 12
);
    logic signed [DATA_W-1:0] lft_spd;
    logic signed [DATA_W-1:0] rght_spd;
    logic                     OVR_I_lft;
    logic                     OVR_I_rght;
    logic                     lft_PWM1;
    logic                     lft_PWM2;
    logic                     rght_PWM1;
    logic                     rght_PWM2;
    logic                     PWM_synch;
    logic                     OVR_I_shtdwn;

    modport master (
        output lft_spd, rght_spd, OVR_I_lft, OVR_I_rght,
        input  lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, OVR_I_shtdwn
    );

    modport slave (
        input  lft_spd, rght_spd, OVR_I_lft, OVR_I_rght,
        output lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, OVR_I_shtdwn
    );
endinterface

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM generator: 2048-clock period, double-buffered duty,
// dead-time insertion and a sticky blanked over-current shutdown.
module mtr_drv #(
    parameter int DATA_W    = 12,
    parameter int DEADTIME  = 32,
    parameter int BLANK     = 128,
    parameter int OVR_LIMIT = 8
) (
    input logic       clk,
    input logic       rst,
    mtr_drv_if.slave  bus
);
    localparam int CNT_W = 11;
    localparam int DT_W  = $clog2(DEADTIME + 1);
    localparam int BL_W  = $clog2(BLANK + 1);
    localparam int OC_W  = $clog2(OVR_LIMIT + 1);

    // Saturate to -1024..+1023, then offset by +1024. Within that range the
    // offset is just an inversion of bit 10 of the 11-bit two's complement.
    function automatic logic [CNT_W-1:0] spd_to_duty(input logic signed [DATA_W-1:0] spd);
        logic signed [DATA_W-1:0] clamped;
        if (spd > DATA_W'(1023))
            clamped = DATA_W'(1023);
        else if (spd < -DATA_W'(1024))
            clamped = -DATA_W'(1024);
        else
            clamped = spd;
        return {~clamped[CNT_W-1], clamped[CNT_W-2:0]};
    endfunction

    logic [CNT_W-1:0]         cnt;
    logic                     synch;
    logic signed [DATA_W-1:0] spd     [2];
    logic [CNT_W-1:0]         duty_q  [2];
    logic [DT_W-1:0]          dt_cnt  [2];
    logic [DT_W-1:0]          dt_nxt  [2];
    logic [BL_W-1:0]          on_cnt  [2];
    logic [1:0]               raw_p0;
    logic [1:0]               raw_p1;
    logic [1:0]               pwm1;
    logic [1:0]               pwm2;
    logic [1:0]               ovr_in;
    logic [1:0]               ovr_evt;
    logic                     ovr_any;
    logic                     ovr_flag;
    logic [OC_W-1:0]          ovr_cnt;
    logic [OC_W-1:0]          ovr_cnt_nxt;
    logic                     shtdwn;
    logic                     shtdwn_nxt;

    always_comb begin
        spd[0]    = bus.lft_spd;
        spd[1]    = bus.rght_spd;
        ovr_in    = {bus.OVR_I_rght, bus.OVR_I_lft};
        raw_p0    = '0;
        ovr_evt   = '0;
        dt_nxt[0] = '0;
        dt_nxt[1] = '0;
        for (int i = 0; i < 2; i++) begin
            raw_p0[i]  = (cnt < duty_q[i]);
            dt_nxt[i]  = (dt_cnt[i] == DT_W'(DEADTIME)) ? dt_cnt[i] : dt_cnt[i] + 1'b1;
            // on_cnt saturates at BLANK, so equality means "blanking elapsed"
            ovr_evt[i] = ovr_in[i] & pwm1[i] & (on_cnt[i] == BL_W'(BLANK));
        end
        ovr_any     = |ovr_evt;
        // An event in the synch cycle itself still counts for the closing period
        if (ovr_flag | ovr_any)
            ovr_cnt_nxt = (ovr_cnt == OC_W'(OVR_LIMIT)) ? ovr_cnt : ovr_cnt + 1'b1;
        else
            ovr_cnt_nxt = '0;
        shtdwn_nxt  = shtdwn | (synch & (ovr_cnt_nxt == OC_W'(OVR_LIMIT)));
    end

    // Stage p0 -> p1: raw compare registered, dead time and gate drives resolved
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            synch    <= 1'b0;
            ovr_flag <= 1'b0;
            ovr_cnt  <= '0;
            shtdwn   <= 1'b0;
            raw_p1   <= 2'b11;
            pwm1     <= '0;
            pwm2     <= '0;
            for (int i = 0; i < 2; i++) begin
                duty_q[i] <= CNT_W'(1024);
                dt_cnt[i] <= '0;
                on_cnt[i] <= '0;
            end
        end else begin
            cnt    <= cnt + 1'b1;
            synch  <= (cnt == CNT_W'(2046));
            shtdwn <= shtdwn_nxt;
            if (synch) begin
                ovr_cnt  <= ovr_cnt_nxt;
                ovr_flag <= 1'b0;
            end else begin
                ovr_flag <= ovr_flag | ovr_any;
            end
            for (int i = 0; i < 2; i++) begin
                if (synch)
                    duty_q[i] <= spd_to_duty(spd[i]);
                raw_p1[i] <= raw_p0[i];
                if (raw_p0[i] != raw_p1[i]) begin
                    dt_cnt[i] <= '0;
                    pwm1[i]   <= 1'b0;
                    pwm2[i]   <= 1'b0;
                end else begin
                    dt_cnt[i] <= dt_nxt[i];
                    // Gate with the next shutdown state so outputs drop with the flag
                    pwm1[i]   <= (dt_nxt[i] == DT_W'(DEADTIME)) &  raw_p1[i] & ~shtdwn_nxt;
                    pwm2[i]   <= (dt_nxt[i] == DT_W'(DEADTIME)) & ~raw_p1[i] & ~shtdwn_nxt;
                end
                if (!pwm1[i])
                    on_cnt[i] <= '0;
                else if (on_cnt[i] != BL_W'(BLANK))
                    on_cnt[i] <= on_cnt[i] + 1'b1;
            end
        end
    end

    assign bus.lft_PWM1     = pwm1[0];
    assign bus.lft_PWM2     = pwm2[0];
    assign bus.rght_PWM1    = pwm1[1];
    assign bus.rght_PWM2    = pwm2[1];
    assign bus.PWM_synch    = synch;
    assign bus.OVR_I_shtdwn = shtdwn;
endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: waveform reference built from "output follows the raw
// PWM once it has been stable for DEADTIME+1 samples", plus period checks.
module tb_mtr_drv;
    localparam int DT  = 32;
    localparam int BLK = 128;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mtr_drv_if bus ();

    mtr_drv #(.DEADTIME(DT), .BLANK(BLK), .OVR_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks;
    int failures;

    // reference model state
    int m_cnt;
    int m_duty [2];
    int last   [2];
    int stab   [2];
    int run    [2];
    int m_flag;
    int m_consec;
    int m_sh;
    int spd_l, spd_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d model_cnt=%0d", tag, obs, exp, m_cnt);
        end
    endtask

    function automatic int duty_of(input int s);
        int c;
        c = (s > 1023) ? 1023 : ((s < -1024) ? -1024 : s);
        return c + 1024;
    endfunction

    task automatic set_spd(input int l, input int r);
        spd_l = l;
        spd_r = r;
        bus.lft_spd  = 12'(l);
        bus.rght_spd = 12'(r);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_flag = 0; m_consec = 0; m_sh = 0;
        for (int s = 0; s < 2; s++) begin
            m_duty[s] = 1024; last[s] = 1; stab[s] = 1; run[s] = 0;
        end
    endtask

    // Compare the current cycle, advance the model with the current inputs, clock.
    task automatic tick();
        logic [1:0] e1, e2, ovr;
        logic [5:0] exp_v, obs_v;
        int ev;
        ovr = {bus.OVR_I_rght, bus.OVR_I_lft};
        for (int s = 0; s < 2; s++) begin
            e1[s] = (m_sh == 0) && (stab[s] >= DT + 1) && (last[s] == 1);
            e2[s] = (m_sh == 0) && (stab[s] >= DT + 1) && (last[s] == 0);
        end
        exp_v = {(m_sh != 0), (m_cnt == 2047), e2[1], e1[1], e2[0], e1[0]};
        obs_v = {bus.OVR_I_shtdwn, bus.PWM_synch, bus.rght_PWM2, bus.rght_PWM1,
                 bus.lft_PWM2, bus.lft_PWM1};
        chk("outputs", 32'(obs_v), 32'(exp_v));
        chk("no_overlap", 32'((bus.lft_PWM1 & bus.lft_PWM2) | (bus.rght_PWM1 & bus.rght_PWM2)), 0);
        if (rst) begin
            model_reset();
        end else begin
            ev = 0;
            for (int s = 0; s < 2; s++) begin
                int raw;
                raw = (m_cnt < m_duty[s]) ? 1 : 0;
                if (raw == last[s]) begin
                    if (stab[s] < 100000) stab[s]++;
                end else begin
                    last[s] = raw;
                    stab[s] = 1;
                end
                if (ovr[s] && e1[s] && run[s] >= BLK) ev = 1;
                run[s] = e1[s] ? ((run[s] + 1 > BLK) ? BLK : run[s] + 1) : 0;
            end
            if (m_cnt == 2047) begin
                if (m_flag != 0 || ev != 0)
                    m_consec = (m_consec + 1 > LIM) ? LIM : m_consec + 1;
                else
                    m_consec = 0;
                if (m_consec >= LIM) m_sh = 1;
                m_flag    = 0;
                m_duty[0] = duty_of(spd_l);
                m_duty[1] = duty_of(spd_r);
            end else if (ev != 0) begin
                m_flag = 1;
            end
            m_cnt = (m_cnt + 1) % 2048;
        end
        @(posedge clk);
        #1;
    endtask

    // One full period, counting high cycles of each gate drive.
    task automatic run_period(output int l1, output int l2, output int r1, output int r2);
        l1 = 0; l2 = 0; r1 = 0; r2 = 0;
        for (int c = 0; c < 2048; c++) begin
            l1 += int'(bus.lft_PWM1);
            l2 += int'(bus.lft_PWM2);
            r1 += int'(bus.rght_PWM1);
            r2 += int'(bus.rght_PWM2);
            tick();
        end
    endtask

    // Left comparator held at a level; right comparator pulsed only while
    // rght_PWM1 is inside its blanking window or low (right duty 1024).
    task automatic ovr_periods(input int n, input logic lft_on);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < 2048; c++) begin
                bus.OVR_I_lft  = lft_on;
                bus.OVR_I_rght = (m_cnt >= 40 && m_cnt <= 100) || (m_cnt >= 1200 && m_cnt <= 1900);
                tick();
            end
        end
        bus.OVR_I_rght = 1'b0;
    endtask

    int l1, l2, r1, r2;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        set_spd(0, 0);
        bus.OVR_I_lft  = 1'b0;
        bus.OVR_I_rght = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_shtdwn", 32'(bus.OVR_I_shtdwn), 0);
        chk("reset_lft_pwm1", 32'(bus.lft_PWM1), 0);

        // P0 at reset duty; left 0 and right +2000 latch at its end
        set_spd(0, 2000);
        run_period(l1, l2, r1, r2);

        // P1: left 50%, right clamped to full; right goes negative mid-period
        l1 = 0; l2 = 0; r1 = 0; r2 = 0;
        for (int c = 0; c < 2048; c++) begin
            if (m_cnt == 1000) set_spd(0, -2000);
            l1 += int'(bus.lft_PWM1);
            l2 += int'(bus.lft_PWM2);
            r1 += int'(bus.rght_PWM1);
            r2 += int'(bus.rght_PWM2);
            tick();
        end
        chk("p1_lft_pwm1_33_1024", l1, 992);
        chk("p1_lft_pwm2_1057_0", l2, 992);
        chk("p1_rght_pwm1_33_2047", r1, 2015);
        // only cnt=0, carried over from the preceding 50% period
        chk("p1_rght_pwm2", r2, 1);

        // P2: left changes to +512 at cnt 500, must not affect this period
        l1 = 0; l2 = 0; r1 = 0; r2 = 0;
        for (int c = 0; c < 2048; c++) begin
            if (m_cnt == 500) set_spd(512, -2000);
            l1 += int'(bus.lft_PWM1);
            l2 += int'(bus.lft_PWM2);
            r1 += int'(bus.rght_PWM1);
            tick();
        end
        chk("p2_lft_pwm1_unchanged", l1, 992);
        chk("p2_lft_pwm2_unchanged", l2, 992);
        chk("p2_rght_pwm1_zero_duty", r1, 0);

        // P3: left duty 1536, right steady at duty 0
        run_period(l1, l2, r1, r2);
        chk("p3_lft_pwm1_33_1536", l1, 1504);
        chk("p3_lft_pwm2_1569_0", l2, 480);
        chk("p3_rght_pwm1", r1, 0);
        chk("p3_rght_pwm2_const", r2, 2048);

        // Random speeds and sporadic left over-current, three periods
        for (int c = 0; c < 3 * 2048; c++) begin
            if ($urandom_range(0, 299) == 0)
                set_spd(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
            if ($urandom_range(0, 199) == 0)
                bus.OVR_I_lft = ~bus.OVR_I_lft;
            tick();
        end
        bus.OVR_I_lft = 1'b0;

        // Setup: clean period latching left +512 / right 0
        set_spd(512, 0);
        run_period(l1, l2, r1, r2);
        chk("setup_no_shtdwn", 32'(bus.OVR_I_shtdwn), 0);

        ovr_periods(4, 1'b0);
        chk("blanked_rght_no_shtdwn", 32'(bus.OVR_I_shtdwn), 0);
        ovr_periods(7, 1'b1);
        chk("seven_periods_no_shtdwn", 32'(bus.OVR_I_shtdwn), 0);
        ovr_periods(1, 1'b0);
        chk("clean_period_no_shtdwn", 32'(bus.OVR_I_shtdwn), 0);
        ovr_periods(7, 1'b1);
        chk("counter_restarted", 32'(bus.OVR_I_shtdwn), 0);
        ovr_periods(1, 1'b1);
        chk("shtdwn_after_8th", 32'(bus.OVR_I_shtdwn), 1);
        chk("shtdwn_pwm_off", 32'({bus.lft_PWM1, bus.lft_PWM2, bus.rght_PWM1, bus.rght_PWM2}), 0);
        bus.OVR_I_lft = 1'b0;

        for (int c = 0; c < 300; c++) tick();
        chk("shtdwn_sticky", 32'(bus.OVR_I_shtdwn), 1);

        // One-clock reset while shut down
        set_spd(0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_clears_shtdwn", 32'(bus.OVR_I_shtdwn), 0);
        chk("rst_clears_synch", 32'(bus.PWM_synch), 0);
        run_period(l1, l2, r1, r2);
        run_period(l1, l2, r1, r2);
        chk("resume_lft_pwm1", l1, 992);
        chk("resume_lft_pwm2", l2, 992);
        chk("resume_rght_pwm1", r1, 992);
        chk("resume_rght_pwm2", r2, 992);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
